// File: rtl/data_memory_responder.sv
// Data-side memory responder: captures a load/store request, waits WAIT_STATES
// cycles, commits to a word-organised little-endian array and pulses ready.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_in_req_w,
    input  logic        mem_in_we2_w,
    input  logic        mem_in_byte_w,
    input  logic [31:0] mem_in_address_w,
    inout  wire  [31:0] mem_data_w,
    output logic        mem_out_ready_l,
    output logic        mem_out_err_l
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic        we_q, byte_q;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, err_q;
    logic        commit;
    logic        drive_en;

    logic [31:0] mem_q [DEPTH_WORDS];

    // With zero wait states the commit edge is also the capture edge, so the
    // commit path must see the live request fields instead of the copies.
    logic [31:0] c_addr, c_wdata;
    logic        c_we, c_byte;
    logic [AW-1:0] c_idx;
    logic [1:0]  c_lane;
    logic        c_err;
    logic [31:0] c_word;
    logic [7:0]  c_bsel;

    always_comb begin
        c_addr  = (state_q == S_IDLE) ? mem_in_address_w : addr_q;
        c_wdata = (state_q == S_IDLE) ? mem_data_w       : wdata_q;
        c_we    = (state_q == S_IDLE) ? mem_in_we2_w     : we_q;
        c_byte  = (state_q == S_IDLE) ? mem_in_byte_w    : byte_q;
        c_idx   = c_addr[AW+1:2];
        c_lane  = c_addr[1:0];
        c_err   = (c_addr >= 32'(4 * DEPTH_WORDS)) || (!c_byte && (c_lane != 2'b00));
        c_word  = mem_q[c_idx];
        case (c_lane)
            2'd0:    c_bsel = c_word[7:0];
            2'd1:    c_bsel = c_word[15:8];
            2'd2:    c_bsel = c_word[23:16];
            default: c_bsel = c_word[31:24];
        endcase
        if (c_err)       rdata_d = 32'h0;
        else if (c_byte) rdata_d = {24'h0, c_bsel};
        else             rdata_d = c_word;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_in_req_w) begin
                    cnt_d = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // An edge taken while reset is high must never commit.
        if (reset) commit = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && mem_in_req_w) begin
                addr_q  <= mem_in_address_w;
                wdata_q <= mem_data_w;
                we_q    <= mem_in_we2_w;
                byte_q  <= mem_in_byte_w;
            end
            if (commit && !c_we) rdata_q <= rdata_d;
            ready_q <= commit;
            err_q   <= commit & c_err;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err) begin
            if (c_byte) mem_q[c_idx][8*c_lane +: 8] <= c_wdata[7:0];
            else        mem_q[c_idx] <= c_wdata;
        end
    end

    assign drive_en        = (state_q == S_RESP) && !we_q;
    assign mem_data_w      = drive_en ? rdata_q : 32'bz;
    assign mem_out_ready_l = ready_q;
    assign mem_out_err_l   = err_q;

endmodule
